wb_io_ctrl: RTL and testbench
=============================

// Module: wb_io_ctrl
// PURPOSE
//  Wishbone-slave pad controller between the Caravel user pads and the user core (darksocv).
//  Each pad is driven either by the core or by a Wishbone-written register, selected per pad.
//  Pad inputs pass through synchronisers; rising edges can raise a maskable interrupt.
//  Successor to the fixed pad hookup: pad count and address window are parametrised, with runtime muxing.
// PARAMETERS
//  NUM_IO      38            pads handled, 1..64
//  BASE_ADDR   32'h3000_0000 start of the 256-byte register window (addr[31:8] match)
//  SYNC_STAGES 2             synchroniser depth on io_in, >=2
//  ID_VALUE    32'h494F_0001 value returned by the ID register
// PORTS
//  wb_clk_i    in   1        single clock
//  wb_rstn_i   in   1        asynchronous, active-low reset
//  wbs_stb_i   in   1        Wishbone strobe
//  wbs_cyc_i   in   1        Wishbone cycle
//  wbs_we_i    in   1        write enable
//  wbs_sel_i   in   4        byte selects
//  wbs_adr_i   in   32       byte address
//  wbs_dat_i   in   32       write data
//  wbs_ack_o   out  1        acknowledge
//  wbs_dat_o   out  32       read data
//  io_in       in   NUM_IO   pad inputs
//  io_out      out  NUM_IO   pad outputs
//  io_oeb      out  NUM_IO   pad output-enable, active-low
//  core_out    in   NUM_IO   core-side pad outputs
//  core_oeb    in   NUM_IO   core-side output enables
//  irq_o       out  1        level interrupt to user_irq
// BEHAVIOUR
//  Register map (LO = bits 31:0, HI = bits NUM_IO-1:32):
//   0x00/04 SEL   0x08/0C OUT   0x10/14 OEB   0x18/1C IN (RO)
//   0x20/24 IE    0x28/2C IS (W1C)   0x30 ID (RO)
//   Other offsets inside the window: read 0, writes ignored, still acked.
//   Bits at index >= NUM_IO read 0; writes to them are ignored.
//  Reset values: SEL=0, OUT=0, OEB=all 1, IE=0, IS=0, sync flops=0.
//   Outputs: wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
//  Bus protocol:
//   Access = stb & cyc & addr[31:8]==BASE_ADDR[31:8].
//   wbs_ack_o registered, asserted 1 cycle after an access; ack <= access & ~ack.
//   This gives one wait state and a single-cycle ack pulse; back-to-back transfers are supported.
//   Writes commit on the edge that raises ack; each wbs_sel_i byte gates its 8 bits.
//   wbs_dat_o is registered with ack and returns 0 whenever ack=0.
//   Accesses outside the window get no ack and change no state.
//  Pad mux, combinational per pad i:
//   SEL[i] ? (io_out=OUT[i], io_oeb=OEB[i]) : (io_out=core_out[i], io_oeb=core_oeb[i]).
//  Input path and edge detection:
//   io_in passes through a SYNC_STAGES flop chain, then one delay flop for edge detection.
//   IN reads the synchronised value.
//  Interrupt status (IS):
//   Rising edge on pad i with IE[i]=1 sets IS[i].
//   Writing 1 to IS[i] clears it; when the set and the clear land in the same cycle, the set wins.
//   Clearing IE[i] masks further edges but leaves IS[i] unchanged.
//  irq_o <= |(IS & IE), registered, so it asserts 1 cycle after IS sets.
//  Latency from pad edge to IS set: SYNC_STAGES+1 cycles.
//  Reset asserted mid-transfer: all state returns to reset values at once; the bus transfer is dropped.
//   No ack is produced for that transfer after reset releases.
// STRUCTURE
//  Shared package wb_io_ctrl_pkg: register offset localparams, WB_ADDR_MASK, default ID_VALUE.
//  One sub-module, io_sync: a WIDTH-wide, STAGES-deep synchroniser with async active-low reset.
//   Instantiated once for all NUM_IO bits.
//  Register file, bus FSM (IDLE/ACK implied by the ack flop) and IRQ logic stay in wb_io_ctrl.
// TESTING
//  Reset -> io_oeb=all 1, io_out follows core_out, irq_o=0; read ID=32'h494F_0001 with ack 1 cycle after stb.
//  Write SEL_LO=0x1, OUT_LO=0x1, OEB_LO=0x0 -> io_out[0]=1, io_oeb[0]=0; pads 1..37 still follow core.
//  Write 0xFFFF_FFFF to SEL_HI with sel=4'b0001 (NUM_IO=38) -> SEL_HI reads 0x3F; bytes 1-3 unchanged.
//  IE_LO=0x4; drive io_in[2] 0->1 -> IS_LO=0x4 after 3 cycles, irq_o=1 a cycle later; W1C 0x4 -> irq_o=0.
//  Edge on io_in[2] in the same cycle as the W1C of IS bit 2 -> IS bit 2 stays 1, irq_o stays 1.
//  Access at BASE_ADDR+0x100 -> no ack, no state change; reset mid-write -> registers at reset values, no ack.

Source files
------------

// File: rtl/wb_io_ctrl_pkg.sv
// Shared definitions for the Wishbone pad controller: register offsets,
// address window mask and the default ID word.
package wb_io_ctrl_pkg;

  localparam logic [7:0] OFF_SEL_LO = 8'h00;
  localparam logic [7:0] OFF_SEL_HI = 8'h04;
  localparam logic [7:0] OFF_OUT_LO = 8'h08;
  localparam logic [7:0] OFF_OUT_HI = 8'h0C;
  localparam logic [7:0] OFF_OEB_LO = 8'h10;
  localparam logic [7:0] OFF_OEB_HI = 8'h14;
  localparam logic [7:0] OFF_IN_LO  = 8'h18;
  localparam logic [7:0] OFF_IN_HI  = 8'h1C;
  localparam logic [7:0] OFF_IE_LO  = 8'h20;
  localparam logic [7:0] OFF_IE_HI  = 8'h24;
  localparam logic [7:0] OFF_IS_LO  = 8'h28;
  localparam logic [7:0] OFF_IS_HI  = 8'h2C;
  localparam logic [7:0] OFF_ID     = 8'h30;

  localparam logic [31:0] WB_ADDR_MASK     = 32'hFFFF_FF00;
  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h494F_0001;

  // Expands the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-bit, multi-stage synchroniser for asynchronous pad inputs.
module io_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wb_io_ctrl.sv
// Wishbone-slave pad controller: per-pad core/register muxing, synchronised
// pad inputs and maskable rising-edge interrupts.
module wb_io_ctrl
  import wb_io_ctrl_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  input  logic [NUM_IO-1:0] core_out,
  input  logic [NUM_IO-1:0] core_oeb,
  output logic              irq_o
);

  // Registers are held 64 bits wide; bits at or above NUM_IO are forced to 0.
  localparam logic [63:0] VALID_MASK = {64{1'b1}} >> (64 - NUM_IO);

  logic [63:0] sel_q, out_q, oeb_q, ie_q, is_q;
  logic [63:0] sel_n, out_n, oeb_n, ie_n, is_n;
  logic [63:0] in_x, rise_x, clr_x;
  logic [NUM_IO-1:0] in_sync, in_dly;
  logic        ack_q, irq_q, access, xfer, wr, hi, unused_adr_bits;
  logic [7:0]  off;
  logic [31:0] wmask, rdata, dat_q;

  function automatic logic [63:0] merge(input logic [63:0] cur, input logic upper,
                                        input logic [31:0] d, input logic [31:0] m);
    logic [63:0] m64;
    logic [63:0] d64;
    m64 = upper ? {m, 32'h0} : {32'h0, m};
    d64 = upper ? {d, 32'h0} : {32'h0, d};
    return ((cur & ~m64) | (d64 & m64)) & VALID_MASK;
  endfunction

  io_sync #(.WIDTH(NUM_IO), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .d     (io_in),
    .q     (in_sync)
  );

  assign access = wbs_stb_i & wbs_cyc_i &
                  ((wbs_adr_i & WB_ADDR_MASK) == (BASE_ADDR & WB_ADDR_MASK));
  assign xfer   = access & ~ack_q;
  assign wr     = xfer & wbs_we_i;
  assign off    = {wbs_adr_i[7:2], 2'b00};
  assign hi     = wbs_adr_i[2];
  assign wmask  = byte_mask(wbs_sel_i);
  assign unused_adr_bits = ^wbs_adr_i[1:0];
  assign in_x   = 64'(in_sync);
  assign rise_x = 64'(in_sync & ~in_dly);

  // Register write decode; IS is write-one-to-clear with a concurrent edge winning.
  always_comb begin
    sel_n = sel_q;
    out_n = out_q;
    oeb_n = oeb_q;
    ie_n  = ie_q;
    clr_x = '0;
    if (wr) begin
      case (off)
        OFF_SEL_LO, OFF_SEL_HI: sel_n = merge(sel_q, hi, wbs_dat_i, wmask);
        OFF_OUT_LO, OFF_OUT_HI: out_n = merge(out_q, hi, wbs_dat_i, wmask);
        OFF_OEB_LO, OFF_OEB_HI: oeb_n = merge(oeb_q, hi, wbs_dat_i, wmask);
        OFF_IE_LO,  OFF_IE_HI:  ie_n  = merge(ie_q,  hi, wbs_dat_i, wmask);
        OFF_IS_LO,  OFF_IS_HI:  clr_x = merge(64'h0, hi, wbs_dat_i, wmask);
        default: ;
      endcase
    end
    is_n = (is_q & ~clr_x) | (rise_x & ie_q);
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_SEL_LO: rdata = sel_q[31:0];
      OFF_SEL_HI: rdata = sel_q[63:32];
      OFF_OUT_LO: rdata = out_q[31:0];
      OFF_OUT_HI: rdata = out_q[63:32];
      OFF_OEB_LO: rdata = oeb_q[31:0];
      OFF_OEB_HI: rdata = oeb_q[63:32];
      OFF_IN_LO:  rdata = in_x[31:0];
      OFF_IN_HI:  rdata = in_x[63:32];
      OFF_IE_LO:  rdata = ie_q[31:0];
      OFF_IE_HI:  rdata = ie_q[63:32];
      OFF_IS_LO:  rdata = is_q[31:0];
      OFF_IS_HI:  rdata = is_q[63:32];
      OFF_ID:     rdata = ID_VALUE;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      sel_q  <= '0;
      out_q  <= '0;
      oeb_q  <= VALID_MASK;
      ie_q   <= '0;
      is_q   <= '0;
      in_dly <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      sel_q  <= sel_n;
      out_q  <= out_n;
      oeb_q  <= oeb_n;
      ie_q   <= ie_n;
      is_q   <= is_n;
      in_dly <= in_sync;
      ack_q  <= xfer;
      dat_q  <= xfer ? rdata : 32'h0;
      irq_q  <= |(is_q & ie_q);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;
  assign io_out = (sel_q[NUM_IO-1:0] & out_q[NUM_IO-1:0]) | (~sel_q[NUM_IO-1:0] & core_out);
  assign io_oeb = (sel_q[NUM_IO-1:0] & oeb_q[NUM_IO-1:0]) | (~sel_q[NUM_IO-1:0] & core_oeb);

endmodule

// File: tb/tb_wb_io_ctrl.sv
// Directed self-checking bench for wb_io_ctrl with the default 38-pad build.
module tb_wb_io_ctrl;

  localparam int          N    = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack;
  logic [31:0]   rdat;
  logic [N-1:0]  io_in, io_out, io_oeb, core_out, core_oeb;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_io_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .core_out  (core_out),
    .core_oeb  (core_oeb),
    .irq_o     (irq)
  );

  // Bus helpers: start #1 after a clock edge, end #1 after the edge following the ack.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic acked);
    adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    acked = ack;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic acked);
    adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    acked = ack;
    d = rdat;
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic a;
    rst_n = 1'b0;
    core_out = 38'h2A_AAAA_AAAA;
    core_oeb = '1;
    #3;
    vectors++;
    if (io_oeb !== {N{1'b1}}) begin miscompares++; $display("[TB] FAIL reset_oeb: got %h expected %h", io_oeb, {N{1'b1}}); end
    vectors++;
    if (io_out !== core_out) begin miscompares++; $display("[TB] FAIL reset_out: got %h expected %h", io_out, core_out); end
    vectors++;
    if ({irq, ack, rdat} !== 34'h0) begin miscompares++; $display("[TB] FAIL reset_outputs: got irq=%b ack=%b dat=%h expected all 0", irq, ack, rdat); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(BASE + 32'h30, d, a);
    vectors++;
    if (a !== 1'b1) begin miscompares++; $display("[TB] FAIL id_ack: got %b expected 1", a); end
    vectors++;
    if (d !== 32'h494F_0001) begin miscompares++; $display("[TB] FAIL id_value: got %h expected 494f0001", d); end
    vectors++;
    if (rdat !== 32'h0) begin miscompares++; $display("[TB] FAIL dat_idle: got %h expected 0", rdat); end
    wb_read(BASE + 32'h14, d, a);
    vectors++;
    if (d !== 32'h3F) begin miscompares++; $display("[TB] FAIL oeb_hi_reset: got %h expected 3f", d); end
  endtask

  task automatic test_pad_mux;
    logic a;
    wb_write(BASE + 32'h00, 32'h1, 4'hF, a);
    wb_write(BASE + 32'h08, 32'h1, 4'hF, a);
    wb_write(BASE + 32'h10, 32'h0, 4'hF, a);
    vectors++;
    if (io_out !== 38'h2A_AAAA_AAAB) begin miscompares++; $display("[TB] FAIL mux_out: got %h expected 2aaaaaaaab", io_out); end
    vectors++;
    if (io_oeb !== 38'h3F_FFFF_FFFE) begin miscompares++; $display("[TB] FAIL mux_oeb: got %h expected 3ffffffffe", io_oeb); end
  endtask

  task automatic test_byte_sel;
    logic [31:0] d;
    logic a;
    wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'b0001, a);
    wb_read(BASE + 32'h04, d, a);
    vectors++;
    if (d !== 32'h3F) begin miscompares++; $display("[TB] FAIL sel_hi_byte0: got %h expected 3f", d); end
    vectors++;
    if (io_out[37:32] !== 6'h00 || io_oeb[37:32] !== 6'h3F) begin
      miscompares++; $display("[TB] FAIL hi_pads_reg: got out=%h oeb=%h expected out=00 oeb=3f", io_out[37:32], io_oeb[37:32]);
    end
    wb_write(BASE + 32'h04, 32'h0, 4'b1110, a);
    wb_read(BASE + 32'h04, d, a);
    vectors++;
    if (d !== 32'h3F) begin miscompares++; $display("[TB] FAIL sel_hi_masked: got %h expected 3f", d); end
    wb_write(BASE + 32'h04, 32'h0, 4'hF, a);
    wb_read(BASE + 32'h04, d, a);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL sel_hi_clear: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic a;
    logic [2:0] acks;
    adr = BASE + 32'h08; wdat = 32'h5; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1; acks[0] = ack;
    adr = BASE + 32'h10; wdat = 32'h3;
    @(posedge clk); #1; acks[1] = ack;
    @(posedge clk); #1; acks[2] = ack;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (acks !== 3'b101) begin miscompares++; $display("[TB] FAIL b2b_ack_pattern: got %b expected 101", acks); end
    wb_read(BASE + 32'h08, d, a);
    vectors++;
    if (d !== 32'h5) begin miscompares++; $display("[TB] FAIL b2b_out: got %h expected 5", d); end
    wb_read(BASE + 32'h10, d, a);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("[TB] FAIL b2b_oeb: got %h expected 3", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic a;
    wb_write(BASE + 32'h20, 32'h4, 4'hF, a);
    io_in[2] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_early: got %b expected 0", irq); end
    @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_rise: got %b expected 1", irq); end
    wb_read(BASE + 32'h28, d, a);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("[TB] FAIL is_set: got %h expected 4", d); end
    wb_read(BASE + 32'h18, d, a);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("[TB] FAIL in_read: got %h expected 4", d); end
    wb_write(BASE + 32'h28, 32'h4, 4'hF, a);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_w1c: got %b expected 0", irq); end
    wb_read(BASE + 32'h28, d, a);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL is_cleared: got %h expected 0", d); end
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    logic a;
    io_in[2] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    io_in[2] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    wb_write(BASE + 32'h28, 32'h4, 4'hF, a);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL set_wins_irq: got %b expected 1", irq); end
    wb_read(BASE + 32'h28, d, a);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("[TB] FAIL set_wins_is: got %h expected 4", d); end
  endtask

  task automatic test_ie_mask;
    logic [31:0] d;
    logic a;
    wb_write(BASE + 32'h20, 32'h0, 4'hF, a);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL ie_off_irq: got %b expected 0", irq); end
    wb_read(BASE + 32'h28, d, a);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("[TB] FAIL ie_off_is_kept: got %h expected 4", d); end
    wb_write(BASE + 32'h28, 32'h4, 4'hF, a);
    io_in[2] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    io_in[2] = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    wb_read(BASE + 32'h28, d, a);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL masked_edge: got %h expected 0", d); end
  endtask

  task automatic test_out_of_window;
    logic [31:0] d;
    logic a;
    logic seen;
    seen = 1'b0;
    adr = BASE + 32'h100; wdat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    repeat (3) begin @(posedge clk); #1; seen |= ack; end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL oow_ack: got %b expected 0", seen); end
    wb_read(BASE + 32'h00, d, a);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("[TB] FAIL oow_sel_kept: got %h expected 1", d); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] d;
    logic a;
    logic seen;
    seen = 1'b0;
    adr = BASE + 32'h08; wdat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ack !== 1'b0 || io_oeb !== core_oeb) begin
      miscompares++; $display("[TB] FAIL midrst_async: got ack=%b oeb=%h expected ack=0 oeb=%h", ack, io_oeb, core_oeb);
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; seen |= ack; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ack: got %b expected 0", seen); end
    wb_read(BASE + 32'h08, d, a);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_out: got %h expected 0", d); end
    wb_read(BASE + 32'h00, d, a);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_sel: got %h expected 0", d); end
    wb_read(BASE + 32'h10, d, a);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL midrst_oeb: got %h expected ffffffff", d); end
  endtask

  initial begin
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    io_in = '0; core_out = '0; core_oeb = '0; rst_n = 1'b0;
    $display("[TB] starting wb_io_ctrl directed tests");
    test_reset();
    test_pad_mux();
    test_byte_sel();
    test_back_to_back();
    test_irq();
    test_set_wins();
    test_ie_mask();
    test_out_of_window();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
